// File: rtl/fifo_lvl.sv
// Synchronous FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds and sticky overflow/underflow flags. Optional FIFO_LVL_FLUSH_EN adds a flush input.
module fifo_lvl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
`ifdef FIFO_LVL_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  rd,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic [ADDR_WIDTH:0]   af_thresh,
  input  logic [ADDR_WIDTH:0]   ae_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int                DEPTH    = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr, r_ptr;
  logic                  flush_now;
  logic                  push, pop;
  logic [ADDR_WIDTH:0]   count_next;

`ifdef FIFO_LVL_FLUSH_EN
  assign flush_now = flush;
`else
  assign flush_now = 1'b0;
`endif

  // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
  assign push = wr && (!full || rd) && !flush_now;
  assign pop  = rd && !empty && !flush_now;

  always_comb begin
    // NOTE: assign a default before any branch so the combinational block never infers a latch.
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + (ADDR_WIDTH+1)'(1);
      2'b01:   count_next = count - (ADDR_WIDTH+1)'(1);
      default: count_next = count;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and count define valid contents.
  always_ff @(posedge clk) begin
    if (push) mem[w_ptr] <= w_data;
  end

  assign r_data = mem[r_ptr];

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else if (flush_now) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      if (push) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (pop)  r_ptr <= r_ptr + ADDR_WIDTH'(1);
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL_CNT);
    end
  end

  // A new error event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd && !flush_now) overflow <= 1'b1;
      else if (err_clr)                    overflow <= 1'b0;
      if (rd && empty && !flush_now)       underflow <= 1'b1;
      else if (err_clr)                    underflow <= 1'b0;
    end
  end

  assign almost_full  = (count >= af_thresh);
  assign almost_empty = (count <= ae_thresh);

endmodule

// File: doc/fifo_lvl.md
Name: fifo_lvl

Overview:
Parametrised synchronous FIFO with a level counter, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags. It is the next-generation buffer for the MMIO UART/SPI/I2C cores, where the CPU polls level and threshold status over the bus. Storage is a register array of 2**ADDR_WIDTH words, with a show-ahead read port.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (every entry usable)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
rd  in  1  pop request
wr  in  1  push request
w_data  in  DATA_WIDTH  push data
af_thresh  in  ADDR_WIDTH+1  almost-full threshold
ae_thresh  in  ADDR_WIDTH+1  almost-empty threshold
err_clr  in  1  clears the sticky error flags
r_data  out  DATA_WIDTH  head-of-queue word (show-ahead)
empty  out  1  count == 0
full  out  1  count == 2**ADDR_WIDTH
count  out  ADDR_WIDTH+1  current occupancy
almost_full  out  1  count >= af_thresh
almost_empty  out  1  count <= ae_thresh
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was issued while empty

Behaviour:
- Reset (async assert, sync release): pointers = 0, count = 0, empty = 1, full = 0, overflow = 0, underflow = 0. Array contents are not reset; r_data is don't-care while empty.
- empty, full, count: registered, and updated on the same clock edge as the pointers.
- almost_full, almost_empty: combinational compares of registered count against the threshold inputs; no extra latency. With default-zero thresholds after reset, almost_empty = 1 and almost_full = 1.
- Effective push: wr && (!full || rd). Effective pop: rd && !empty.
- r_data = mem[r_ptr], combinational. A written word is visible on r_data the cycle after the write edge. A pop advances r_ptr, and the next word appears the following cycle.
- Pointers are ADDR_WIDTH bits and wrap modulo depth naturally. count is tracked explicitly:
  - +1 on push only
  - -1 on pop only
  - unchanged on push+pop, or on neither
- Simultaneous rd & wr:
  - Not empty and not full: both occur; count is unchanged.
  - Full: both occur (pop frees a slot); count stays at depth; no overflow.
  - Empty: write only, count -> 1, underflow set.
- wr while full and !rd: data dropped, no state change except overflow <= 1.
- rd while empty: no pointer change; underflow <= 1.
- overflow and underflow hold until err_clr. If err_clr and a new error event fall in the same cycle, the event wins (flag = 1).
- Reset mid-operation discards all contents; the first cycle after release behaves as a fresh FIFO.

Optional Feature:
Macro FIFO_LVL_FLUSH_EN.
- Defined: adds input port flush (1 bit). Synchronous: on a clock edge with flush = 1, pointers and count clear to 0 (empty = 1, full = 0). rd/wr in that cycle are ignored. Error flags are not affected.
- Undefined: the port is absent and no flush logic is generated.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 -> count = 3, r_data = 0x11; one rd -> r_data = 0x22, count = 2.
- ADDR_WIDTH = 4: 16 writes -> full = 1, count = 16; 17th write (no rd) -> dropped, overflow = 1, count = 16; err_clr -> overflow = 0.
- Full FIFO, rd & wr of 0xAA in the same cycle -> count stays 16, full stays 1, overflow = 0; after 16 pops, last word read = 0xAA.
- Empty FIFO, rd & wr of 0x5C together -> count = 1, underflow = 1, r_data = 0x5C next cycle.
- af_thresh = 12, ae_thresh = 3: fill 0 -> 16 and drain -> almost_empty high for counts 0..3, almost_full high for counts 12..16; push/pop 40 words to exercise pointer wrap, with data order preserved.
- Reset asserted mid-stream at count = 9, asynchronously between edges -> count = 0, empty = 1, flags = 0 immediately. With FIFO_LVL_FLUSH_EN: flush at count = 7 plus rd & wr -> count = 0 next edge, write ignored.
